// File: rtl/io_write_arbiter_pkg.sv
// Shared constants and types for the button-to-regfile write arbiter.
// Buttons map to registers IO_REG_BASE + index (UP=1, DOWN=2, LEFT=3, RIGHT=4).
package io_write_arbiter_pkg;

    localparam int unsigned NUM_BTNS    = 4;
    localparam int unsigned IO_REG_BASE = 1;

    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StResync   = 2'd1,
        StActive   = 2'd2
    } arb_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button.
// 'changed' is high in the cycle whose closing edge flips 'level'.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic raw,
    output logic level,
    output logic changed
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    assign changed = (sync2_q != level_q) && (cnt_q == CntLast);
    assign level   = level_q;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (changed) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_write_arbiter.sv
// Shares the regfile write port between processor writeback and four debounced buttons.
// Processor writes always win; button events are injected round-robin on idle cycles.
module io_write_arbiter
    import io_write_arbiter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        proc_writeEnable,
    input  logic [4:0]  proc_writeReg,
    input  logic [31:0] proc_writeData,
    input  logic        btn_UP,
    input  logic        btn_DOWN,
    input  logic        btn_LEFT,
    input  logic        btn_RIGHT,
    input  logic        io_enable,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [3:0]  io_pending,
    output logic [7:0]  io_overrun
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] changed;

    assign raw = {btn_RIGHT, btn_LEFT, btn_DOWN, btn_UP};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock     (clock),
            .ctrl_reset(ctrl_reset),
            .raw       (raw[i]),
            .level     (level[i]),
            .changed   (changed[i])
        );
    end

    arb_state_e          state_q;
    logic [NUM_BTNS-1:0] pend_valid_q;
    logic [NUM_BTNS-1:0] pend_val_q;
    logic [1:0]          rr_ptr_q;
    logic [7:0]          overrun_q;

    logic                grant;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = '0;
        if (!proc_writeEnable && state_q == StActive) begin
            for (int k = NUM_BTNS - 1; k >= 0; k--) begin
                cand = rr_ptr_q + 2'(k);
                if (pend_valid_q[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (proc_writeEnable) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = proc_writeReg;
            data_writeReg    = proc_writeData;
        end else if (grant) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'(grant_idx) + 5'(IO_REG_BASE);
            data_writeReg    = {31'b0, pend_val_q[grant_idx]};
        end
    end

    logic [NUM_BTNS-1:0] act_valid;
    logic [NUM_BTNS-1:0] act_val;
    logic [2:0]          ovr_add;
    logic [8:0]          ovr_sum;
    logic [7:0]          ovr_next;

    // A new event on the button being granted this cycle replaces a completed write,
    // so only events landing on a still-pending slot count as overruns.
    always_comb begin
        act_valid = pend_valid_q;
        act_val   = pend_val_q;
        ovr_add   = '0;
        if (grant) begin
            act_valid[grant_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (changed[i]) begin
                if (pend_valid_q[i] && !(grant && grant_idx == 2'(i))) begin
                    ovr_add = ovr_add + 3'd1;
                end
                act_valid[i] = 1'b1;
                act_val[i]   = ~level[i];
            end
        end
        ovr_sum  = {1'b0, overrun_q} + 9'(ovr_add);
        ovr_next = ovr_sum[8] ? 8'hff : ovr_sum[7:0];
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q      <= StDisabled;
            pend_valid_q <= '0;
            pend_val_q   <= '0;
            rr_ptr_q     <= '0;
            overrun_q    <= '0;
        end else begin
            unique case (state_q)
                StDisabled: begin
                    pend_valid_q <= '0;
                    if (io_enable) state_q <= StResync;
                end
                StResync: begin
                    // Republish every button level; round robin restarts from UP.
                    pend_valid_q <= '1;
                    pend_val_q   <= level ^ changed;
                    rr_ptr_q     <= '0;
                    state_q      <= StActive;
                end
                StActive: begin
                    if (grant) rr_ptr_q <= rr_next(grant_idx);
                    if (!io_enable) begin
                        pend_valid_q <= '0;
                        state_q      <= StDisabled;
                    end else begin
                        pend_valid_q <= act_valid;
                        pend_val_q   <= act_val;
                        overrun_q    <= ovr_next;
                    end
                end
                default: state_q <= StDisabled;
            endcase
        end
    end

    assign io_pending = pend_valid_q;
    assign io_overrun = overrun_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter: expected writes are queued with their cycle,
// and a monitor process checks every write the DUT presents.
module tb_io_write_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        proc_writeEnable;
    logic [4:0]  proc_writeReg;
    logic [31:0] proc_writeData;
    logic        btn_UP, btn_DOWN, btn_LEFT, btn_RIGHT;
    logic        io_enable;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [3:0]  io_pending;
    logic [7:0]  io_overrun;

    io_write_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .proc_writeEnable(proc_writeEnable),
        .proc_writeReg   (proc_writeReg),
        .proc_writeData  (proc_writeData),
        .btn_UP          (btn_UP),
        .btn_DOWN        (btn_DOWN),
        .btn_LEFT        (btn_LEFT),
        .btn_RIGHT       (btn_RIGHT),
        .io_enable       (io_enable),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .io_pending      (io_pending),
        .io_overrun      (io_overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input int c);
        exp_t e;
        e.r = r;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (ctrl_writeEnable === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got reg %0d data %0h at cycle %0d, want none",
                             ctrl_writeReg, data_writeReg, cyc);
                end else begin
                    e = q.pop_front();
                    if (ctrl_writeReg !== e.r || data_writeReg !== e.d || cyc != e.c) begin
                        n_fail++;
                        $display("FAIL write: got reg %0d data %0h cycle %0d, want reg %0d data %0h cycle %0d",
                                 ctrl_writeReg, data_writeReg, cyc, e.r, e.d, e.c);
                    end
                end
            end else if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0
                         || data_writeReg !== 32'd0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL idle_outputs: got we %b reg %0d data %0h at cycle %0d, want 0/0/0",
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg, cyc);
            end
        end
    endtask

    int n;
    int m;

    initial begin
        ctrl_reset       = 1'b1;
        proc_writeEnable = 1'b0;
        proc_writeReg    = '0;
        proc_writeData   = '0;
        btn_UP           = 1'b0;
        btn_DOWN         = 1'b0;
        btn_LEFT         = 1'b0;
        btn_RIGHT        = 1'b0;
        io_enable        = 1'b0;
        fork
            monitor();
        join_none

        #3;
        check("reset_we", 32'(ctrl_writeEnable), 32'd0);
        check("reset_pending", 32'(io_pending), 32'd0);
        check("reset_overrun", 32'(io_overrun), 32'd0);
        tick(2);
        ctrl_reset = 1'b0;
        tick();

        // Write to register 0 passes through untouched.
        proc_writeEnable = 1'b1;
        proc_writeReg    = 5'd0;
        proc_writeData   = 32'h1234_5678;
        expect_wr(5'd0, 32'h1234_5678, cyc);
        tick();
        proc_writeEnable = 1'b0;

        // First enable: resync publishes all-zero levels to regs 1..4.
        n = cyc;
        io_enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'd0, n + 2 + i);
        tick(8);
        check("after_resync_pending", 32'(io_pending), 32'd0);

        // 3-cycle glitch is shorter than the debounce window.
        btn_UP = 1'b1;
        tick(3);
        btn_UP = 1'b0;
        tick(10);
        check("glitch_pending", 32'(io_pending), 32'd0);

        // Simultaneous events held off by 5 processor writes.
        n = cyc;
        btn_UP    = 1'b1;
        btn_DOWN  = 1'b1;
        btn_RIGHT = 1'b1;
        tick(6);
        proc_writeEnable = 1'b1;
        proc_writeReg    = 5'd7;
        proc_writeData   = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            expect_wr(5'd7, 32'hDEAD_BEEF, cyc);
            tick();
        end
        check("starved_pending", 32'(io_pending), 32'b1011);
        proc_writeEnable = 1'b0;
        expect_wr(5'd1, 32'd1, n + 11);
        expect_wr(5'd2, 32'd1, n + 12);
        expect_wr(5'd4, 32'd1, n + 13);
        tick(6);

        n = cyc;
        btn_UP    = 1'b0;
        btn_DOWN  = 1'b0;
        btn_RIGHT = 1'b0;
        expect_wr(5'd1, 32'd0, n + 6);
        expect_wr(5'd2, 32'd0, n + 7);
        expect_wr(5'd4, 32'd0, n + 8);
        tick(12);

        // LEFT press and release, 6-cycle latency each.
        n = cyc;
        btn_LEFT = 1'b1;
        expect_wr(5'd3, 32'd1, n + 6);
        tick(10);
        m = cyc;
        btn_LEFT = 1'b0;
        expect_wr(5'd3, 32'd0, m + 6);
        tick(10);
        check("left_done_pending", 32'(io_pending), 32'd0);
        check("no_overrun_yet", 32'(io_overrun), 32'd0);

        // Busy processor writing reg 2: DOWN press then release overwrites pending.
        proc_writeEnable = 1'b1;
        proc_writeReg    = 5'd2;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) btn_DOWN = 1'b1;
            if (i == 10) btn_DOWN = 1'b0;
            proc_writeData = 32'(i);
            expect_wr(5'd2, 32'(i), cyc);
            tick();
        end
        check("overrun_count", 32'(io_overrun), 32'd1);
        check("overrun_pending", 32'(io_pending), 32'b0010);
        proc_writeEnable = 1'b0;
        expect_wr(5'd2, 32'd0, cyc);
        tick();
        check("overrun_drained", 32'(io_pending), 32'd0);

        // Re-enable while RIGHT is held.
        io_enable = 1'b0;
        tick();
        btn_RIGHT = 1'b1;
        tick(10);
        check("disabled_pending", 32'(io_pending), 32'd0);
        n = cyc;
        io_enable = 1'b1;
        expect_wr(5'd1, 32'd0, n + 2);
        expect_wr(5'd2, 32'd0, n + 3);
        expect_wr(5'd3, 32'd0, n + 4);
        expect_wr(5'd4, 32'd1, n + 5);
        tick(8);

        // Build pending 1011 under a busy processor, then reset.
        proc_writeEnable = 1'b1;
        proc_writeReg    = 5'd9;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                btn_UP    = 1'b1;
                btn_DOWN  = 1'b1;
                btn_RIGHT = 1'b0;
            end
            proc_writeData = 32'(i + 100);
            expect_wr(5'd9, 32'(i + 100), cyc);
            tick();
        end
        check("prereset_pending", 32'(io_pending), 32'b1011);
        check("prereset_overrun", 32'(io_overrun), 32'd1);
        ctrl_reset       = 1'b1;
        proc_writeEnable = 1'b0;
        io_enable        = 1'b0;
        btn_UP           = 1'b0;
        btn_DOWN         = 1'b0;
        #1;
        check("async_reset_pending", 32'(io_pending), 32'd0);
        check("async_reset_overrun", 32'(io_overrun), 32'd0);
        check("async_reset_we", 32'(ctrl_writeEnable), 32'd0);
        tick(2);
        ctrl_reset = 1'b0;
        tick(15);
        check("post_reset_pending", 32'(io_pending), 32'd0);

        check("leftover_expected", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_write_arbiter.md
Name: io_write_arbiter

Overview:
Shares the register file's single write port between processor writeback and the four board buttons. Processor writes always pass through with zero latency. Each button is synchronised, debounced and edge-detected. Press and release events are queued as pending writes (value 1 or 0) into registers 1–4, and are injected on idle write-port cycles in round-robin order. The block sits between the processor writeback stage and the regfile write inputs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before a new button level is accepted (min 1)
CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  in  1  system clock; all state on rising edge
ctrl_reset  in  1  asynchronous, active-high reset
proc_writeEnable  in  1  processor writeback request
proc_writeReg  in  5  processor destination register
proc_writeData  in  32  processor write data
btn_UP, btn_DOWN, btn_LEFT, btn_RIGHT  in  1 each  raw asynchronous buttons (index 0..3)
io_enable  in  1  button injection enable (board switch)
ctrl_writeEnable  out  1  to regfile
ctrl_writeReg  out  5  to regfile
data_writeReg  out  32  to regfile
io_pending  out  4  pending-event flags, bit i = button i
io_overrun  out  8  saturating count of overwritten pending events

Behaviour:
- Reset (async, immediate): sync flops, debounced levels, debounce counters, pending valid/value, rr pointer, overrun = 0; state = DISABLED. Combinational outputs then follow the rules below, so only processor pass-through is visible.
- Synchroniser: 2-flop per button. Debounce: counter clears whenever the synced sample equals the debounced level. Otherwise it increments; when the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. Raw-edge to debounced-change latency = 2 + DEBOUNCE_CYCLES cycles.
- Event: a debounced change on button i in state ACTIVE sets pend_valid[i] = 1 and pend_val[i] = new level.
  - If pend_valid[i] was already 1 and is not being granted this cycle, the value is overwritten (latest wins) and io_overrun increments, saturating at 255.
  - If the same button is granted and gets a new event in the same cycle, the grant completes and the new event becomes pending. This case is not an overrun.
- FSM:
  - DISABLED: no injection, pending held at 0, events ignored. io_enable=1 → RESYNC.
  - RESYNC (1 cycle): pend_valid = 4'b1111, pend_val = current debounced levels → ACTIVE.
  - ACTIVE: normal operation. io_enable=0 → DISABLED, clearing all pending on that edge.
- Arbitration (combinational outputs):
  - If proc_writeEnable=1: pass proc_writeReg/proc_writeData through, ctrl_writeEnable=1, no grant.
  - Else, in ACTIVE with any pend_valid: grant the first valid index at or after rr_ptr, circularly. Outputs ctrl_writeEnable=1, ctrl_writeReg = index+1, data_writeReg = {31'b0, pend_val}. On the clock edge, clear that pend_valid and set rr_ptr = index+1 mod 4.
  - Else: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- Processor writes to registers 1–4 do not clear pending; the later button write still lands.
- Processor writes to register 0 pass through unchanged.
- The processor is never stalled. Button events may starve indefinitely; only overruns are counted.
- Reset mid-operation discards all pending events; no write is issued after reset asserts.

Decomposition:
- Shared package: NUM_BTNS=4, IO_REG_BASE=1 (UP=1, DOWN=2, LEFT=3, RIGHT=4), FSM state encoding (DISABLED, RESYNC, ACTIVE).
- Sub-module btn_debounce: synchroniser, debounce counter and change pulse. Ports: clock, ctrl_reset, raw, level, changed. Instantiated 4×.
- Arbiter, FSM and overrun counter live in the top module.

Test Plan:
- DEBOUNCE_CYCLES=4, io_enable=1, proc idle: assert btn_LEFT at cycle 10 → ACTIVE. A write to reg 3 with data 1 appears on cycle 16, single cycle. Release the button → a write to reg 3 with data 0 appears 6 cycles after release.
- btn_UP glitches high for 3 cycles → no write issued; io_pending stays 0.
- UP, DOWN and RIGHT events arrive in the same cycle while the processor holds proc_writeEnable=1, proc_writeReg=7, proc_writeData=0xDEADBEEF for 5 cycles → only reg7 writes during those cycles. Then writes to reg 1, 2, 4 in consecutive cycles.
- Processor continuously writing; btn_DOWN press then release → io_overrun=1, io_pending=4'b0010. Processor then idles → one write to reg 2 with data 0.
- io_enable 0→1 while btn_RIGHT is held (debounced 1) → after RESYNC, four writes: reg1=0, reg2=0, reg3=0, reg4=1.
- Assert ctrl_reset with pending 4'b1011 → io_pending=0 and io_overrun=0 immediately, and no button write occurs after release until a new event.
